// File: rtl/dataslot_req_arbiter.sv
// Round-robin arbiter sharing the single core-initiated dataslot request channel
// among NUM_REQ requesters; one request is outstanding at a time.
module dataslot_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*16-1:0] req_slot_id,
   input  logic [NUM_REQ*32-1:0] req_slot_offset,
   input  logic [NUM_REQ*32-1:0] req_bridge_addr,
   input  logic [NUM_REQ*32-1:0] req_length,
   output logic [NUM_REQ-1:0]    req_accept,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [2:0]            req_result,
   output logic                  ds_valid,
   output logic                  ds_write,
   output logic [15:0]           ds_slot_id,
   output logic [31:0]           ds_slot_offset,
   output logic [31:0]           ds_bridge_addr,
   output logic [31:0]           ds_length,
   input  logic                  ds_ack,
   input  logic                  ds_done,
   input  logic [2:0]            ds_result,
   output logic                  busy
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0] ResTimeout = 3'd7;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_q, rr_d;
   logic [IdxW-1:0]   gnt_q, gnt_d;
   logic [23:0]       cnt_q, cnt_d;
   logic [2:0]        result_q, result_d;
   logic              ds_valid_q, ds_valid_d;
   logic              busy_q, busy_d;
   logic              ds_write_q, ds_write_d;
   logic [15:0]       ds_slot_id_q, ds_slot_id_d;
   logic [31:0]       ds_slot_offset_q, ds_slot_offset_d;
   logic [31:0]       ds_bridge_addr_q, ds_bridge_addr_d;
   logic [31:0]       ds_length_q, ds_length_d;

   logic [15:0]       slot_arr   [NUM_REQ];
   logic [31:0]       offset_arr [NUM_REQ];
   logic [31:0]       bridge_arr [NUM_REQ];
   logic [31:0]       length_arr [NUM_REQ];

   logic              found;
   logic [IdxW-1:0]   pick;
   logic [IdxW-1:0]   cand;
   logic [NUM_REQ-1:0] accept;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign slot_arr[gi]   = req_slot_id[16*gi +: 16];
      assign offset_arr[gi] = req_slot_offset[32*gi +: 32];
      assign bridge_arr[gi] = req_bridge_addr[32*gi +: 32];
      assign length_arr[gi] = req_length[32*gi +: 32];
   end

   // First pending requester at or after rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IdxW'((int'(rr_q) + i) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      rr_d             = rr_q;
      gnt_d            = gnt_q;
      cnt_d            = cnt_q;
      result_d         = result_q;
      ds_write_d       = ds_write_q;
      ds_slot_id_d     = ds_slot_id_q;
      ds_slot_offset_d = ds_slot_offset_q;
      ds_bridge_addr_d = ds_bridge_addr_q;
      ds_length_d      = ds_length_q;
      accept           = '0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d            = pick;
               accept[pick]     = 1'b1;
               ds_write_d       = req_write[pick];
               ds_slot_id_d     = slot_arr[pick];
               ds_slot_offset_d = offset_arr[pick];
               ds_bridge_addr_d = bridge_arr[pick];
               ds_length_d      = length_arr[pick];
               state_d          = StIssue;
            end
         end
         StIssue: begin
            if (ds_ack) begin
               cnt_d = '0;
               if (ds_done) begin
                  result_d = ds_result;
                  state_d  = StRespond;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            // A completion arriving on the timeout cycle takes priority.
            if (ds_done) begin
               result_d = ds_result;
               state_d  = StRespond;
            end else if ((TIMEOUT != 24'd0) && (cnt_q == TIMEOUT - 24'd1)) begin
               result_d = ResTimeout;
               state_d  = StRespond;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         StRespond: begin
            rr_d    = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + IdxW'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      ds_valid_d = (state_d == StIssue);
      busy_d     = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= StIdle;
         rr_q             <= '0;
         gnt_q            <= '0;
         cnt_q            <= '0;
         result_q         <= '0;
         ds_valid_q       <= 1'b0;
         busy_q           <= 1'b0;
         ds_write_q       <= 1'b0;
         ds_slot_id_q     <= '0;
         ds_slot_offset_q <= '0;
         ds_bridge_addr_q <= '0;
         ds_length_q      <= '0;
      end else begin
         state_q          <= state_d;
         rr_q             <= rr_d;
         gnt_q            <= gnt_d;
         cnt_q            <= cnt_d;
         result_q         <= result_d;
         ds_valid_q       <= ds_valid_d;
         busy_q           <= busy_d;
         ds_write_q       <= ds_write_d;
         ds_slot_id_q     <= ds_slot_id_d;
         ds_slot_offset_q <= ds_slot_offset_d;
         ds_bridge_addr_q <= ds_bridge_addr_d;
         ds_length_q      <= ds_length_d;
      end
   end

   always_comb begin
      req_done = '0;
      if (state_q == StRespond) begin
         req_done[gnt_q] = 1'b1;
      end
   end

   // Grant is combinational from req_valid, so mask it while reset is held.
   assign req_accept     = reset ? '0 : accept;
   assign req_result     = (state_q == StRespond) ? result_q : 3'd0;
   assign ds_valid       = ds_valid_q;
   assign ds_write       = ds_write_q;
   assign ds_slot_id     = ds_slot_id_q;
   assign ds_slot_offset = ds_slot_offset_q;
   assign ds_bridge_addr = ds_bridge_addr_q;
   assign ds_length      = ds_length_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_dataslot_req_arbiter.sv
// Directed bench for dataslot_req_arbiter: a transaction table plus hand-written
// timeout, stray-input and mid-operation reset sequences.
module tb_dataslot_req_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_write;
   logic [63:0] req_slot_id;
   logic [127:0] req_slot_offset;
   logic [127:0] req_bridge_addr;
   logic [127:0] req_length;
   logic [3:0]  req_accept;
   logic [3:0]  req_done;
   logic [2:0]  req_result;
   logic        ds_valid;
   logic        ds_write;
   logic [15:0] ds_slot_id;
   logic [31:0] ds_slot_offset;
   logic [31:0] ds_bridge_addr;
   logic [31:0] ds_length;
   logic        ds_ack;
   logic        ds_done;
   logic [2:0]  ds_result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   dataslot_req_arbiter #(
      .NUM_REQ (4),
      .TIMEOUT (24'd16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_write       (req_write),
      .req_slot_id     (req_slot_id),
      .req_slot_offset (req_slot_offset),
      .req_bridge_addr (req_bridge_addr),
      .req_length      (req_length),
      .req_accept      (req_accept),
      .req_done        (req_done),
      .req_result      (req_result),
      .ds_valid        (ds_valid),
      .ds_write        (ds_write),
      .ds_slot_id      (ds_slot_id),
      .ds_slot_offset  (ds_slot_offset),
      .ds_bridge_addr  (ds_bridge_addr),
      .ds_length       (ds_length),
      .ds_ack          (ds_ack),
      .ds_done         (ds_done),
      .ds_result       (ds_result),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [3:0]  wr;
      logic        same;
      logic [2:0]  res;
      int unsigned g;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_slot(input int unsigned i);
      return 16'(i + 2);
   endfunction
   function automatic logic [31:0] exp_off(input int unsigned i);
      return 32'(32'h1000 * i + 4);
   endfunction
   function automatic logic [31:0] exp_bridge(input int unsigned i);
      return 32'(32'h8000_0000 + 32'h1_0000 * i);
   endfunction
   function automatic logic [31:0] exp_len(input int unsigned i);
      return 32'(32'h100 * (i + 1));
   endfunction

   task automatic set_fields;
      for (int i = 0; i < 4; i++) begin
         req_slot_id[16*i +: 16]     = exp_slot(i);
         req_slot_offset[32*i +: 32] = exp_off(i);
         req_bridge_addr[32*i +: 32] = exp_bridge(i);
         req_length[32*i +: 32]      = exp_len(i);
      end
   endtask

   task automatic spoil_fields;
      req_slot_id     = '1;
      req_slot_offset = '1;
      req_bridge_addr = '1;
      req_length      = '1;
   endtask

   // Starts in the cycle before IDLE arbitration; ends in the RESPOND cycle.
   task automatic run_txn(input vec_t v);
      logic [3:0] oh;
      oh = 4'(1 << v.g);
      step;
      req_valid = v.mask;
      req_write = v.wr;
      set_fields();
      #1;
      chk("accept", req_accept, oh);
      chk("busy_idle", busy, 0);
      step;
      req_valid = v.mask & ~oh;
      req_write = ~v.wr;
      spoil_fields();
      #1;
      chk("ds_valid", ds_valid, 1);
      chk("ds_write", ds_write, v.wr[v.g]);
      chk("ds_slot_id", ds_slot_id, exp_slot(v.g));
      chk("ds_slot_offset", ds_slot_offset, exp_off(v.g));
      chk("ds_bridge_addr", ds_bridge_addr, exp_bridge(v.g));
      chk("ds_length", ds_length, exp_len(v.g));
      chk("accept_issue", req_accept, 0);
      chk("busy_issue", busy, 1);
      ds_ack    = 1'b1;
      ds_done   = v.same;
      ds_result = v.res;
      step;
      ds_ack  = 1'b0;
      ds_done = 1'b0;
      #1;
      if (!v.same) begin
         chk("ds_valid_wait", ds_valid, 0);
         chk("done_early", req_done, 0);
         ds_done   = 1'b1;
         ds_result = v.res;
         step;
         ds_done   = 1'b0;
         ds_result = 3'd0;
         #1;
      end
      chk("req_done", req_done, oh);
      chk("req_result", req_result, v.res);
      req_valid = 4'b0;
   endtask

   task automatic run_timeout(input logic coincide, input logic [3:0] mask,
                              input int unsigned g);
      logic [3:0] oh;
      oh = 4'(1 << g);
      step;
      req_valid = mask;
      set_fields();
      #1;
      chk("to_accept", req_accept, oh);
      step;
      req_valid = 4'b0;
      ds_ack    = 1'b1;
      #1;
      chk("to_ds_valid", ds_valid, 1);
      for (int k = 1; k <= 16; k++) begin
         step;
         ds_ack = 1'b0;
         if (coincide && k == 16) begin
            ds_done   = 1'b1;
            ds_result = 3'd2;
         end
         #1;
         chk("to_no_done", req_done, 0);
         chk("to_busy", busy, 1);
      end
      step;
      ds_done   = 1'b0;
      ds_result = 3'd0;
      #1;
      chk("to_req_done", req_done, oh);
      chk("to_result", req_result, coincide ? 3'd2 : 3'd7);
      step;
      #1;
      chk("to_busy_after", busy, 0);
      chk("to_done_after", req_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{mask: 4'b1111, wr: 4'b0000, same: 1'b1, res: 3'd0, g: 0};
      vecs[1] = '{mask: 4'b1111, wr: 4'b1111, same: 1'b0, res: 3'd1, g: 1};
      vecs[2] = '{mask: 4'b1111, wr: 4'b0101, same: 1'b1, res: 3'd3, g: 2};
      vecs[3] = '{mask: 4'b1111, wr: 4'b1010, same: 1'b0, res: 3'd4, g: 3};
      vecs[4] = '{mask: 4'b1111, wr: 4'b1111, same: 1'b1, res: 3'd6, g: 0};
      vecs[5] = '{mask: 4'b0010, wr: 4'b0000, same: 1'b0, res: 3'd0, g: 1};
      vecs[6] = '{mask: 4'b1001, wr: 4'b1000, same: 1'b0, res: 3'd5, g: 3};
      vecs[7] = '{mask: 4'b0110, wr: 4'b0010, same: 1'b1, res: 3'd2, g: 1};
      vecs[8] = '{mask: 4'b1011, wr: 4'b1011, same: 1'b0, res: 3'd7, g: 3};

      reset     = 1'b1;
      req_valid = 4'b0;
      req_write = 4'b0;
      ds_ack    = 1'b0;
      ds_done   = 1'b0;
      ds_result = 3'd0;
      set_fields();
      #2;
      chk("rst_ds_valid", ds_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", req_done, 0);
      chk("rst_slot", ds_slot_id, 0);
      step;
      step;
      reset = 1'b0;

      foreach (vecs[i]) run_txn(vecs[i]);

      // Stray ack/done while idle
      step;
      ds_ack    = 1'b1;
      ds_done   = 1'b1;
      ds_result = 3'd5;
      #1;
      chk("stray_busy0", busy, 0);
      step;
      ds_ack    = 1'b0;
      ds_done   = 1'b0;
      ds_result = 3'd0;
      #1;
      chk("stray_busy", busy, 0);
      chk("stray_ds_valid", ds_valid, 0);
      chk("stray_done", req_done, 0);
      step;
      #1;
      chk("stray_done2", req_done, 0);
      chk("stray_busy2", busy, 0);

      run_timeout(1'b0, 4'b0001, 0);
      run_timeout(1'b1, 4'b0001, 0);

      run_txn('{mask: 4'b0100, wr: 4'b0000, same: 1'b1, res: 3'd1, g: 2});

      // Request 3 in WAIT, then reset; pointer would favour 3 without the reset
      step;
      req_valid = 4'b1000;
      #1;
      chk("mid_accept", req_accept, 4'b1000);
      step;
      req_valid = 4'b0;
      ds_ack    = 1'b1;
      step;
      ds_ack = 1'b0;
      #1;
      chk("mid_busy", busy, 1);
      req_valid = 4'b1100;
      reset     = 1'b1;
      #1;
      chk("mid_rst_ds_valid", ds_valid, 0);
      chk("mid_rst_fields", {ds_write, ds_slot_id, ds_length}, 0);
      chk("mid_rst_offaddr", {ds_slot_offset, ds_bridge_addr}, 0);
      chk("mid_rst_accept", req_accept, 0);
      chk("mid_rst_done", req_done, 0);
      chk("mid_rst_result", req_result, 0);
      chk("mid_rst_busy", busy, 0);
      step;
      reset     = 1'b0;
      req_valid = 4'b0;
      #1;
      chk("mid_post_done", req_done, 0);
      run_txn('{mask: 4'b1100, wr: 4'b0100, same: 1'b0, res: 3'd3, g: 2});
      step;
      #1;
      chk("final_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dataslot_req_arbiter.md
# dataslot_req_arbiter

Shares the single core-initiated dataslot request channel (the core_dataslot_read / core_dataslot_write path toward the host bridge) among NUM_REQ independent requesters inside the core. It selects one pending request round-robin, holds its command on the channel until accepted, and waits for the host's completion or a timeout. It then returns a one-cycle completion with a result code to the originating requester. Only one request is ever outstanding.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 24'd12_000_000: cycles allowed in WAIT before abort; 0 disables the timeout.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending; held until req_accept.
- req_write  in  NUM_REQ  1 = dataslot write, 0 = dataslot read.
- req_slot_id  in  NUM_REQ*16  slot id, requester i at bits [16i+15:16i].
- req_slot_offset  in  NUM_REQ*32  byte offset within the slot.
- req_bridge_addr  in  NUM_REQ*32  bridge address of the buffer.
- req_length  in  NUM_REQ*32  transfer length in bytes.
- req_accept  out  NUM_REQ  one-hot one-cycle pulse; the request was latched.
- req_done  out  NUM_REQ  one-hot one-cycle pulse; completion for that requester.
- req_result  out  3  result code, valid only while req_done != 0.
- ds_valid  out  1  command presented downstream.
- ds_write  out  1  registered copy of the granted req_write.
- ds_slot_id  out  16  registered slot id.
- ds_slot_offset  out  32  registered offset.
- ds_bridge_addr  out  32  registered bridge address.
- ds_length  out  32  registered length.
- ds_ack  in  1  downstream accepted the command (pulse).
- ds_done  in  1  host completion (pulse).
- ds_result  in  3  host result code, valid with ds_done.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit is the grant g.
  - On a grant: latch g's fields into the ds_* registers, pulse req_accept[g], and go to ISSUE.
  - With no request pending, stay in IDLE.
- ISSUE
  - ds_valid=1 with fields stable.
  - On ds_ack, drop ds_valid and go to WAIT.
  - If ds_done also arrives in the ack cycle, capture ds_result and go directly to RESPOND.
- WAIT
  - Count cycles in a 24-bit counter cleared on entry.
  - On ds_done, capture ds_result and go to RESPOND.
  - If TIMEOUT!=0 and the count reaches TIMEOUT-1 without ds_done, set result=3'd7 (timeout) and go to RESPOND.
  - If ds_done and the timeout hit occur in the same cycle, ds_done wins and ds_result is used.
- RESPOND
  - req_done[g]=1 and req_result=captured value for exactly one cycle.
  - rr_ptr := (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - Return to IDLE.
- ds_ack outside ISSUE and ds_done outside ISSUE/WAIT are ignored; they are never buffered.
- A requester may deassert req_valid only after req_accept. Changes to its fields after acceptance have no effect.
- Reset, whether idle or mid-operation: state=IDLE, rr_ptr=0, counter=0, and all outputs 0 (ds_valid, ds_* fields, req_accept, req_done, req_result, busy). An in-flight request is dropped with no req_done.

## Timing
- Grant cycle: req_valid sampled in IDLE at cycle T. req_accept pulses in T. The ds_* fields are registered at the end of T, so ds_valid=1 from T+1.
- Minimum request-to-done: ds_ack at T+1, ds_done at T+2, req_done at T+3.
- Same-cycle ack and done at T+1 gives req_done at T+2.
- IDLE re-arbitration resumes the cycle after RESPOND. Back-to-back grants are therefore at least 3 cycles apart.
- busy = (state != IDLE), registered along with the state.
- Timeout fires on the TIMEOUT-th cycle in WAIT. req_done follows one cycle later.

## Test plan
- Single request: reset, then req_valid[1]=1, read, slot 16'h0003, length 32'h200. Check req_accept[1] at T, ds_valid at T+1 with the matching fields, and req_done[1] with req_result=3'd0 after ds_ack/ds_done with ds_result=0.
- Round-robin fairness: req_valid=4'b1111 held, with immediate ack and done each request. Grants must be 0,1,2,3,0. Then with rr_ptr=2 and only req 0 and req 3 valid, the grant must be 3.
- Timeout: TIMEOUT=16, ds_ack given, ds_done never. Check req_done with req_result=3'd7 exactly 17 cycles after WAIT entry, and busy=0 afterwards.
- Simultaneous events: ds_ack and ds_done in the same cycle gives req_done the next cycle. ds_done coinciding with the timeout hit returns ds_result=3'd2, not 7.
- Stray inputs: pulse ds_ack and ds_done while in IDLE. There must be no state change, no req_done, and ds_valid stays 0.
- Reset mid-operation: assert reset in WAIT. All outputs are 0 immediately (asynchronous), with no req_done. After release, a new request to id 2 is granted with rr_ptr=0 order.
